// File: rtl/ryg_pkg.sv
// Shared types and constants for the RYG lamp driver and its upstream phase controller.
package ryg_pkg;

  typedef enum logic [1:0] {
    PhJ     = 2'd0,
    PhP     = 2'd1,
    PhC     = 2'd2,
    PhFault = 2'd3
  } phase_e;

  localparam int unsigned LampR = 2;
  localparam int unsigned LampY = 1;
  localparam int unsigned LampG = 0;

  localparam int unsigned DefaultL = 10;
  localparam int unsigned DefaultS = 3;

  function automatic logic [7:0] phase_len(phase_e ph, int unsigned l, int unsigned s);
    case (ph)
      PhJ:     return 8'(l + s);
      PhP:     return 8'(l - s);
      PhC:     return 8'(l + 2 * s);
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] vehicle_lamp(logic active, logic warn);
    logic [2:0] lamp;
    lamp = '0;
    if (!active)   lamp[LampR] = 1'b1;
    else if (warn) lamp[LampY] = 1'b1;
    else           lamp[LampG] = 1'b1;
    return lamp;
  endfunction

endpackage

// File: rtl/ryg_onehot_chk.sv
// Decodes the upstream J/P/C pass levels into a validity flag and the named phase.
module ryg_onehot_chk
  import ryg_pkg::*;
(
  input  logic   j,
  input  logic   p,
  input  logic   c,
  output logic   valid,
  output phase_e target
);

  always_comb begin
    valid  = 1'b0;
    target = PhJ;
    case ({j, p, c})
      3'b100: begin valid = 1'b1; target = PhJ; end
      3'b010: begin valid = 1'b1; target = PhP; end
      3'b001: begin valid = 1'b1; target = PhC; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ryg_lamp.sv
// Lamp driver following the upstream phase controller, with countdown and fault blinking.
module ryg_lamp
  import ryg_pkg::*;
#(
  parameter int unsigned L = DefaultL,
  parameter int unsigned S = DefaultS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       J,
  input  logic       P,
  input  logic       C,
  output logic [2:0] J_lamp,
  output logic [2:0] C_lamp,
  output logic [2:0] P_lamp,
  output logic [7:0] remain,
  output logic       fault
);

  if (!(L > S && L + 2 * S <= 255)) begin : g_param_check
    $error("ryg_lamp: require L > S and L + 2*S <= 255");
  end

  localparam logic [7:0] Warn = 8'(S);

  phase_e     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic       blink_q, blink_d;
  logic       inv_q, inv_d;      // previous edge sampled an invalid pattern
  logic       val_q, val_d;      // in fault: previous edge sampled a valid pattern
  phase_e     tgt_q, tgt_d;
  logic [2:0] j_lamp_q, j_lamp_d, c_lamp_q, c_lamp_d, p_lamp_q, p_lamp_d;
  logic       fault_q, fault_d;

  logic   valid;
  phase_e target;

  ryg_onehot_chk u_onehot_chk (
    .j      (J),
    .p      (P),
    .c      (C),
    .valid  (valid),
    .target (target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PhJ;
      remain_q <= phase_len(PhJ, L, S);
      blink_q  <= 1'b0;
      inv_q    <= 1'b0;
      val_q    <= 1'b0;
      tgt_q    <= PhJ;
      j_lamp_q <= 3'b001;
      c_lamp_q <= 3'b100;
      p_lamp_q <= 3'b100;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      blink_q  <= blink_d;
      inv_q    <= inv_d;
      val_q    <= val_d;
      tgt_q    <= tgt_d;
      j_lamp_q <= j_lamp_d;
      c_lamp_q <= c_lamp_d;
      p_lamp_q <= p_lamp_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    inv_d    = inv_q;
    val_d    = val_q;
    tgt_d    = tgt_q;
    if (state_q == PhFault) begin
      inv_d = 1'b0;
      if (!valid) begin
        val_d = 1'b0;
      end else if (val_q && tgt_q == target) begin
        state_d  = target;
        remain_d = phase_len(target, L, S);
        val_d    = 1'b0;
      end else begin
        val_d = 1'b1;
        tgt_d = target;
      end
    end else begin
      val_d = 1'b0;
      if (valid) begin
        inv_d = 1'b0;
        if (target != state_q) begin
          state_d  = target;
          remain_d = phase_len(target, L, S);
        end else if (remain_q > 8'd1) begin
          remain_d = remain_q - 8'd1;
        end
      end else if (inv_q) begin
        state_d  = PhFault;
        remain_d = 8'd0;
        inv_d    = 1'b0;
      end else begin
        inv_d = 1'b1;  // first invalid sample is only remembered
      end
    end

    // Blinking always starts lit on the first tick of fault or pedestrian warning.
    if (state_d == PhFault) begin
      blink_d = (state_q == PhFault) ? ~blink_q : 1'b1;
    end else if (state_d == PhP && remain_d <= Warn) begin
      blink_d = (state_q == PhP && remain_q <= Warn) ? ~blink_q : 1'b1;
    end else begin
      blink_d = 1'b0;
    end
  end

  always_comb begin
    fault_d  = (state_d == PhFault);
    j_lamp_d = vehicle_lamp(state_d == PhJ, remain_d <= Warn);
    c_lamp_d = vehicle_lamp(state_d == PhC, remain_d <= Warn);
    p_lamp_d = 3'b100;
    if (state_d == PhFault) begin
      j_lamp_d = '0;
      c_lamp_d = '0;
      p_lamp_d = '0;
      j_lamp_d[LampY] = blink_d;
      c_lamp_d[LampY] = blink_d;
      p_lamp_d[LampR] = blink_d;
    end else if (state_d == PhP) begin
      p_lamp_d = '0;
      p_lamp_d[LampG] = (remain_d > Warn) ? 1'b1 : blink_d;
    end
  end

  assign J_lamp = j_lamp_q;
  assign C_lamp = c_lamp_q;
  assign P_lamp = p_lamp_q;
  assign remain = remain_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_ryg_lamp.sv
// Scoreboard bench for ryg_lamp: a behavioural model predicts each edge's outputs.
module tb_ryg_lamp;

  localparam int L = 10;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       J, P, C;
  logic [2:0] J_lamp, C_lamp, P_lamp;
  logic [7:0] remain;
  logic       fault;

  ryg_lamp #(.L(L), .S(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .J      (J),
    .P      (P),
    .C      (C),
    .J_lamp (J_lamp),
    .C_lamp (C_lamp),
    .P_lamp (P_lamp),
    .remain (remain),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] jl;
    logic [2:0] cl;
    logic [2:0] pl;
    logic [7:0] rem;
    logic       flt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: phase 0=J 1=P 2=C 3=fault; run counters replace blink flip-flops.
  int m_ph, m_rem, m_bad, m_good, m_gtgt, m_fcnt, m_wcnt;
  bit m_was_fault, m_was_pwarn;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(int ph);
    case (ph)
      0:       return L + S;
      1:       return L - S;
      default: return L + 2 * S;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = L + S; m_bad = 0; m_good = 0; m_gtgt = 0;
    m_fcnt = 0; m_wcnt = 0; m_was_fault = 0; m_was_pwarn = 0;
  endtask

  task automatic model_step(input logic j, input logic p, input logic c);
    int  n, t;
    bit  ok, pwarn;
    n  = int'(j) + int'(p) + int'(c);
    ok = (n == 1);
    t  = j ? 0 : (p ? 1 : 2);
    if (m_ph != 3) begin
      if (ok) begin
        m_bad = 0;
        if (t != m_ph) begin m_ph = t; m_rem = len_of(t); end
        else if (m_rem > 1) m_rem--;
      end else begin
        m_bad++;
        if (m_bad >= 2) begin m_ph = 3; m_rem = 0; m_bad = 0; end
      end
    end else begin
      if (ok) begin
        if (m_good > 0 && m_gtgt == t) begin m_ph = t; m_rem = len_of(t); m_good = 0; end
        else begin m_good = 1; m_gtgt = t; end
      end else begin
        m_good = 0;
      end
    end
    if (m_ph == 3) m_fcnt = m_was_fault ? m_fcnt + 1 : 0;
    pwarn = (m_ph == 1 && m_rem <= S);
    if (pwarn) m_wcnt = m_was_pwarn ? m_wcnt + 1 : 0;
    m_was_fault = (m_ph == 3);
    m_was_pwarn = pwarn;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   lit;
    e.jl = 3'b100; e.cl = 3'b100; e.pl = 3'b100;
    e.rem = 8'(m_rem);
    e.flt = (m_ph == 3);
    case (m_ph)
      0: e.jl = (m_rem > S) ? 3'b001 : 3'b010;
      2: e.cl = (m_rem > S) ? 3'b001 : 3'b010;
      1: e.pl = (m_rem > S) ? 3'b001 : ((m_wcnt % 2 == 0) ? 3'b001 : 3'b000);
      default: begin
        lit  = (m_fcnt % 2 == 0);
        e.jl = lit ? 3'b010 : 3'b000;
        e.cl = lit ? 3'b010 : 3'b000;
        e.pl = lit ? 3'b100 : 3'b000;
      end
    endcase
    return e;
  endfunction

  task automatic tick(input logic j, input logic p, input logic c);
    exp_t e;
    J = j; P = p; C = c;
    model_step(j, p, c);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("J_lamp", J_lamp, e.jl);
    check_eq("C_lamp", C_lamp, e.cl);
    check_eq("P_lamp", P_lamp, e.pl);
    check_eq("remain", remain, e.rem);
    check_eq("fault",  fault,  e.flt);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_J_lamp"}, J_lamp, 3'b001);
    check_eq({tag, "_C_lamp"}, C_lamp, 3'b100);
    check_eq({tag, "_P_lamp"}, P_lamp, 3'b100);
    check_eq({tag, "_remain"}, remain, L + S);
    check_eq({tag, "_fault"},  fault,  0);
  endtask

  initial begin
    int r;
    rst = 1'b1; J = 1'b0; P = 1'b0; C = 1'b0;
    model_reset();
    #12;
    check_reset_values("rst");
    rst = 1'b0;

    repeat (12) tick(1, 0, 0);
    tick(0, 1, 0);
    check_eq("p_switch_remain", remain, L - S);
    check_eq("p_switch_lamp", P_lamp, 3'b001);
    repeat (6) tick(0, 1, 0);
    repeat (20) tick(0, 0, 1);
    check_eq("c_hold_remain", remain, 1);
    check_eq("c_hold_lamp", C_lamp, 3'b010);

    repeat (3) tick(1, 0, 0);
    tick(1, 0, 1);                     // lone glitch is ignored
    repeat (2) tick(1, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 1);
    check_eq("fault_flag", fault, 1);
    check_eq("fault_remain", remain, 0);
    repeat (3) tick(1, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 0);                     // breaks the valid run
    tick(0, 0, 1);
    tick(0, 0, 1);
    check_eq("fault_exit_remain", remain, L + 2 * S);
    check_eq("fault_exit_flag", fault, 0);
    repeat (3) tick(0, 0, 1);

    // Asynchronous reset between edges, mid PH_C.
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    rst = 1'b0;
    model_reset();
    #1;
    repeat (4) tick(1, 0, 0);

    // Mixed pattern run, mostly valid with occasional invalid samples.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: tick(1, 0, 0);
        3, 4:    tick(0, 1, 0);
        5, 6, 7: tick(0, 0, 1);
        8:       tick(0, 1, 1);
        default: tick(0, 0, 0);
      endcase
    end
    repeat (10) tick(0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
